// File: rtl/lutram_arbiter.sv
// Two-port round-robin arbiter in front of a shared 16x32 LUT RAM.
// After reset the RAM is swept with INIT_VALUE before any client is granted.

module LUTRAM #(
  parameter string BACKEND = "behavioral"
) (
  input  logic        clk,
  input  logic [3:0]  addr_i,
  input  logic [3:0]  strobe_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o
);

  // Asynchronous read and byte-enabled synchronous write.
  // A same-cycle read of the written word therefore sees the old contents.
  if (BACKEND == "xilinx_xpm") begin : g_xpm
    (* ram_style = "distributed" *) logic [31:0] mem [16];

    always_ff @(posedge clk) begin
      for (int b = 0; b < 4; b++) begin
        if (strobe_i[b]) mem[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end

    assign rdata_o = mem[addr_i];
  end else begin : g_behav
    logic [31:0] mem [16];

    always_ff @(posedge clk) begin
      for (int b = 0; b < 4; b++) begin
        if (strobe_i[b]) mem[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end

    assign rdata_o = mem[addr_i];
  end

endmodule

module lutram_arbiter #(
  parameter string       BACKEND    = "behavioral",
  parameter logic [31:0] INIT_VALUE = 32'h0
) (
  input  logic        clk,
  input  logic        resetn,
  output logic        init_done,
  input  logic        p0_valid,
  output logic        p0_ready,
  input  logic [3:0]  p0_addr,
  input  logic [3:0]  p0_strobe,
  input  logic [31:0] p0_wdata,
  output logic [31:0] p0_rdata,
  input  logic        p1_valid,
  output logic        p1_ready,
  input  logic [3:0]  p1_addr,
  input  logic [3:0]  p1_strobe,
  input  logic [31:0] p1_wdata,
  output logic [31:0] p1_rdata
);

  typedef enum logic {INIT, RUN} state_e;

  state_e      state_q;
  logic [3:0]  cnt_q;
  logic [3:0]  cnt_d;
  logic        last_q;
  logic        last_d;
  logic        init_done_q;

  logic        gnt0;
  logic        gnt1;
  logic [3:0]  ram_addr;
  logic [3:0]  ram_strobe;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;

  // last_q names the port served most recently; under contention the other one wins.
  always_comb begin
    gnt0   = 1'b0;
    gnt1   = 1'b0;
    last_d = last_q;
    if (state_q == RUN) begin
      if (p0_valid && p1_valid) begin
        gnt0 = last_q;
        gnt1 = !last_q;
      end else begin
        gnt0 = p0_valid;
        gnt1 = p1_valid;
      end
      if (gnt0) last_d = 1'b0;
      else if (gnt1) last_d = 1'b1;
    end
  end

  always_comb begin
    ram_addr   = '0;
    ram_strobe = '0;
    ram_wdata  = '0;
    cnt_d      = cnt_q + 4'd1;
    if (state_q == INIT) begin
      ram_addr   = cnt_q;
      ram_strobe = 4'b1111;
      ram_wdata  = INIT_VALUE;
    end else if (gnt0) begin
      ram_addr   = p0_addr;
      ram_strobe = p0_strobe;
      ram_wdata  = p0_wdata;
    end else if (gnt1) begin
      ram_addr   = p1_addr;
      ram_strobe = p1_strobe;
      ram_wdata  = p1_wdata;
    end
  end

  // The clear finishes on the edge that writes entry 15.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= INIT;
      cnt_q       <= '0;
      last_q      <= 1'b1;
      init_done_q <= 1'b0;
    end else begin
      case (state_q)
        INIT: begin
          cnt_q <= cnt_d;
          if (cnt_q == 4'd15) begin
            state_q     <= RUN;
            init_done_q <= 1'b1;
          end
        end
        RUN: begin
          last_q <= last_d;
        end
        default: state_q <= INIT;
      endcase
    end
  end

  LUTRAM #(
    .BACKEND(BACKEND)
  ) u_ram (
    .clk     (clk),
    .addr_i  (ram_addr),
    .strobe_i(ram_strobe),
    .wdata_i (ram_wdata),
    .rdata_o (ram_rdata)
  );

  assign init_done = init_done_q;
  assign p0_ready  = gnt0;
  assign p1_ready  = gnt1;
  assign p0_rdata  = ram_rdata;
  assign p1_rdata  = ram_rdata;

endmodule

// File: tb/tb_lutram_arbiter.sv
// Directed bench for lutram_arbiter: clear sequence, reads/writes, byte strobes,
// round-robin contention and mid-run reset.

module tb_lutram_arbiter;

  logic        clk = 1'b0;
  logic        resetn;
  logic        init_done;
  logic        p0_valid, p1_valid;
  logic        p0_ready, p1_ready;
  logic [3:0]  p0_addr, p1_addr;
  logic [3:0]  p0_strobe, p1_strobe;
  logic [31:0] p0_wdata, p1_wdata;
  logic [31:0] p0_rdata, p1_rdata;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  lutram_arbiter #(
    .BACKEND   ("behavioral"),
    .INIT_VALUE(32'h0)
  ) dut (
    .clk      (clk),
    .resetn   (resetn),
    .init_done(init_done),
    .p0_valid (p0_valid),
    .p0_ready (p0_ready),
    .p0_addr  (p0_addr),
    .p0_strobe(p0_strobe),
    .p0_wdata (p0_wdata),
    .p0_rdata (p0_rdata),
    .p1_valid (p1_valid),
    .p1_ready (p1_ready),
    .p1_addr  (p1_addr),
    .p1_strobe(p1_strobe),
    .p1_wdata (p1_wdata),
    .p1_rdata (p1_rdata)
  );

  // Drives both ports and lets the combinational grant/read paths settle.
  task automatic applyStimulus(input logic v0, input logic [3:0] a0, input logic [3:0] s0,
                               input logic [31:0] d0, input logic v1, input logic [3:0] a1,
                               input logic [3:0] s1, input logic [31:0] d1);
    p0_valid  = v0;
    p0_addr   = a0;
    p0_strobe = s0;
    p0_wdata  = d0;
    p1_valid  = v1;
    p1_addr   = a1;
    p1_strobe = s1;
    p1_wdata  = d1;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 4'd0, 4'd0, 32'h0, 1'b0, 4'd0, 4'd0, 32'h0);
  endtask

  initial begin
    resetn = 1'b0;
    idle();
    #11;
    checkOutput("rst_init_done", {31'b0, init_done}, 32'd0);
    checkOutput("rst_p0_ready", {31'b0, p0_ready}, 32'd0);
    checkOutput("rst_p1_ready", {31'b0, p1_ready}, 32'd0);

    @(negedge clk);
    resetn = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      tick();
      checkOutput($sformatf("clear_done_e%0d", k), {31'b0, init_done},
                  (k == 16) ? 32'd1 : 32'd0);
    end

    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b1, 4'(i), 4'd0, 32'h0, 1'b0, 4'd0, 4'd0, 32'h0);
      checkOutput($sformatf("init_rd_a%0d", i), p0_rdata, 32'h0);
      if (i == 0) checkOutput("init_rd_ready", {31'b0, p0_ready}, 32'd1);
      tick();
    end

    applyStimulus(1'b1, 4'd0, 4'hf, 32'hdeadbeef, 1'b0, 4'd0, 4'd0, 32'h0);
    checkOutput("wr0_p0_ready", {31'b0, p0_ready}, 32'd1);
    tick();
    applyStimulus(1'b0, 4'd0, 4'd0, 32'h0, 1'b1, 4'd0, 4'd0, 32'h0);
    checkOutput("rd0_p1_ready", {31'b0, p1_ready}, 32'd1);
    checkOutput("rd0_p1_rdata", p1_rdata, 32'hdeadbeef);
    tick();

    applyStimulus(1'b1, 4'd15, 4'b0101, 32'hcccccccc, 1'b0, 4'd0, 4'd0, 32'h0);
    tick();
    applyStimulus(1'b0, 4'd0, 4'd0, 32'h0, 1'b1, 4'd14, 4'b1010, 32'h12345678);
    tick();
    applyStimulus(1'b1, 4'd15, 4'd0, 32'h0, 1'b0, 4'd0, 4'd0, 32'h0);
    checkOutput("strb_a15", p0_rdata, 32'h00cc00cc);
    tick();
    applyStimulus(1'b0, 4'd0, 4'd0, 32'h0, 1'b1, 4'd14, 4'd0, 32'h0);
    checkOutput("strb_a14", p1_rdata, 32'h12005600);
    tick();

    // Port 1 was served last, so contention starts with port 0.
    for (int c = 0; c < 4; c++) begin
      applyStimulus(1'b1, 4'd1, 4'hf, 32'h11111111, 1'b1, 4'd1, 4'hf, 32'h22222222);
      checkOutput($sformatf("rr_p0_c%0d", c), {31'b0, p0_ready}, (c % 2 == 0) ? 32'd1 : 32'd0);
      checkOutput($sformatf("rr_p1_c%0d", c), {31'b0, p1_ready}, (c % 2 == 1) ? 32'd1 : 32'd0);
      tick();
    end
    applyStimulus(1'b1, 4'd1, 4'd0, 32'h0, 1'b0, 4'd0, 4'd0, 32'h0);
    checkOutput("rr_final_a1", p0_rdata, 32'h22222222);
    tick();

    applyStimulus(1'b1, 4'd1, 4'hf, 32'h33333333, 1'b0, 4'd0, 4'd0, 32'h0);
    checkOutput("rdw_old_data", p0_rdata, 32'h22222222);
    tick();
    applyStimulus(1'b0, 4'd0, 4'd0, 32'h0, 1'b1, 4'd1, 4'd0, 32'h0);
    checkOutput("rdw_new_data", p1_rdata, 32'h33333333);
    tick();

    applyStimulus(1'b1, 4'd3, 4'hf, 32'h19260817, 1'b0, 4'd0, 4'd0, 32'h0);
    tick();
    applyStimulus(1'b0, 4'd0, 4'd0, 32'h0, 1'b1, 4'd3, 4'd0, 32'h0);
    checkOutput("a3_written", p1_rdata, 32'h19260817);
    tick();

    applyStimulus(1'b0, 4'd0, 4'd0, 32'h0, 1'b1, 4'd3, 4'hf, 32'hffffffff);
    checkOutput("mid_p1_ready", {31'b0, p1_ready}, 32'd1);
    #2;
    resetn = 1'b0;
    #1;
    checkOutput("mid_rst_done", {31'b0, init_done}, 32'd0);
    checkOutput("mid_rst_p1_ready", {31'b0, p1_ready}, 32'd0);
    applyStimulus(1'b1, 4'd3, 4'd0, 32'h0, 1'b1, 4'd3, 4'd0, 32'h0);
    @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      tick();
      checkOutput($sformatf("reclear_done_e%0d", k), {31'b0, init_done},
                  (k == 16) ? 32'd1 : 32'd0);
      checkOutput($sformatf("reclear_p0_ready_e%0d", k), {31'b0, p0_ready},
                  (k == 16) ? 32'd1 : 32'd0);
      checkOutput($sformatf("reclear_p1_ready_e%0d", k), {31'b0, p1_ready}, 32'd0);
    end
    checkOutput("a3_cleared", p0_rdata, 32'h0);
    tick();
    checkOutput("post_p1_ready", {31'b0, p1_ready}, 32'd1);
    checkOutput("post_p0_ready", {31'b0, p0_ready}, 32'd0);
    idle();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
